// File: rtl/md5_mem_responder.sv
// Fixed-latency memory responder for the HLS md5 core's RAM master port: message and digest regions.
// Define MD5_MEM_RESP_STATS_EN to add the rd_count / wr_count / last_addr statistics outputs.
module md5_mem_responder #(
  parameter logic [63:0] IN_BASE  = 64'h4000_0000,
  parameter logic [63:0] OUT_BASE = 64'h4000_0100,
  parameter int          IN_WORDS = 8,
  parameter int          RESP_LAT = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          Mout_oe_ram,
  input  logic                                          Mout_we_ram,
  input  logic [63:0]                                   Mout_addr_ram,
  input  logic [63:0]                                   Mout_Wdata_ram,
  input  logic [11:0]                                   Mout_data_ram_size,
  output logic [63:0]                                   M_Rdata_ram,
  output logic                                          M_DataRdy,
  input  logic                                          load_valid,
  input  logic [$clog2(IN_WORDS > 1 ? IN_WORDS : 2)-1:0] load_index,
  input  logic [63:0]                                   load_data,
  output logic                                          digest_valid,
  output logic [127:0]                                  digest,
`ifdef MD5_MEM_RESP_STATS_EN
  output logic [15:0]                                   rd_count,
  output logic [15:0]                                   wr_count,
  output logic [63:0]                                   last_addr,
`endif
  output logic                                          err_sticky
);

  localparam int          IDX_W     = $clog2(IN_WORDS > 1 ? IN_WORDS : 2);
  localparam logic [63:0] IN_LIMIT  = IN_BASE + 64'(8 * IN_WORDS);
  localparam logic [63:0] OUT_LIMIT = OUT_BASE + 64'd16;
  localparam logic [63:0] OUT_W1    = OUT_BASE + 64'd8;
  localparam logic [3:0]  CNT_LAST  = (RESP_LAT >= 2) ? 4'(RESP_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  lat_cnt;

  logic        req_rd_p0;
  logic        req_wr_p0;
  logic        req_both_p0;
  logic [63:0] req_addr_p0;
  logic [63:0] req_wdata_p0;
  logic [11:0] req_size_p0;

  logic [63:0] msg_mem [IN_WORDS];
  logic [63:0] dig_word [2];
  logic [1:0]  written;

  logic             in_hit;
  logic             out_hit;
  logic             req_err;
  logic [IDX_W-1:0] widx;
  logic             dsel;
  logic [2:0]       boff;
  logic [3:0]       nbytes;
  logic [63:0]      tgt_word;

  function automatic logic size_legal(input logic [11:0] sz);
    return (sz == 12'd8) || (sz == 12'd16) || (sz == 12'd32) || (sz == 12'd64);
  endfunction

  // Illegal widths fall back to a full 64-bit access.
  function automatic logic [3:0] size_bytes(input logic [11:0] sz);
    case (sz)
      12'd8:   return 4'd1;
      12'd16:  return 4'd2;
      12'd32:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] read_extract(input logic [63:0] word, input logic [2:0] off,
                                               input logic [3:0] nb);
    logic [63:0] sh;
    logic [63:0] res;
    sh  = word >> {off, 3'b000};
    res = '0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < nb) res[8*j +: 8] = sh[8*j +: 8];
    end
    return res;
  endfunction

  // Lanes past byte 7 simply do not exist, which truncates word-crossing writes.
  function automatic logic [63:0] write_merge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [2:0] off, input logic [3:0] nb);
    logic [63:0] sh;
    logic [63:0] res;
    sh  = wd << {off, 3'b000};
    res = old;
    for (int j = 0; j < 8; j++) begin
      if ((4'(j) >= {1'b0, off}) && (4'(j) < ({1'b0, off} + nb))) res[8*j +: 8] = sh[8*j +: 8];
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    in_hit   = (req_addr_p0 >= IN_BASE) && (req_addr_p0 < IN_LIMIT);
    out_hit  = (req_addr_p0 >= OUT_BASE) && (req_addr_p0 < OUT_LIMIT);
    widx     = IDX_W'((req_addr_p0 - IN_BASE) >> 3);
    dsel     = (req_addr_p0 >= OUT_W1);
    boff     = req_addr_p0[2:0];
    nbytes   = size_bytes(req_size_p0);
    req_err  = !(in_hit || out_hit) || req_both_p0 || !size_legal(req_size_p0) ||
               (({1'b0, boff} + nbytes) > 4'd8);
    tgt_word = in_hit ? msg_mem[widx] : (out_hit ? dig_word[dsel] : 64'd0);
  end

  // p0: request captured on the accepting edge; oe&we together is served as a read
  always_ff @(posedge clk) begin
    if (state == IDLE && (Mout_oe_ram || Mout_we_ram)) begin
      req_rd_p0    <= Mout_oe_ram;
      req_wr_p0    <= Mout_we_ram && !Mout_oe_ram;
      req_both_p0  <= Mout_oe_ram && Mout_we_ram;
      req_addr_p0  <= Mout_addr_ram;
      req_wdata_p0 <= Mout_Wdata_ram;
      req_size_p0  <= Mout_data_ram_size;
    end
  end

  // RESP is the last cycle before the strobe; the strobe cycle itself is IDLE, so a
  // back-to-back request presented alongside M_DataRdy is accepted immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      M_DataRdy   <= 1'b0;
      M_Rdata_ram <= '0;
      err_sticky  <= 1'b0;
      written     <= '0;
      dig_word[0] <= '0;
      dig_word[1] <= '0;
    end else begin
      M_DataRdy   <= 1'b0;
      M_Rdata_ram <= '0;
      case (state)
        IDLE: begin
          if (Mout_oe_ram || Mout_we_ram) begin
            lat_cnt <= '0;
            state   <= (RESP_LAT <= 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == CNT_LAST) state <= RESP;
          else                     lat_cnt <= lat_cnt + 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          M_DataRdy <= 1'b1;
          if (req_rd_p0) M_Rdata_ram <= read_extract(tgt_word, boff, nbytes);
          if (req_wr_p0 && out_hit) begin
            dig_word[dsel] <= write_merge(tgt_word, req_wdata_p0, boff, nbytes);
            written[dsel]  <= 1'b1;
          end
          if (req_err) err_sticky <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Message region survives reset; a same-cycle preload overrides the core write.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && req_wr_p0 && in_hit)
      msg_mem[widx] <= write_merge(tgt_word, req_wdata_p0, boff, nbytes);
    if (load_valid)
      msg_mem[load_index] <= load_data;
  end

  assign digest       = {dig_word[1], dig_word[0]};
  assign digest_valid = &written;

`ifdef MD5_MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      last_addr <= '0;
    end else if (state == RESP) begin
      if (req_rd_p0) rd_count <= sat_inc(rd_count);
      if (req_wr_p0) wr_count <= sat_inc(wr_count);
      last_addr <= req_addr_p0;
    end
  end
`endif

endmodule
